// File: rtl/anf_pkg.sv
// Shared definitions for the ANF pipeline: scan FSM states, popcount helper and
// width helpers sized from log2 of the vector length.
package anf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } anf_state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c += {31'd0, v[i]};
    end
    return c;
  endfunction

  // Degree never exceeds log2(N), so it needs clog2(log2(N)+1) bits.
  function automatic int unsigned deg_width(input int unsigned log2_n);
    return $clog2(log2_n + 1);
  endfunction

  // Monomial count ranges 0..N inclusive.
  function automatic int unsigned cnt_width(input int unsigned log2_n);
    return log2_n + 1;
  endfunction

endpackage

// File: rtl/anf_lane_reduce.sv
// Combinational reduction of one scan chunk: number of set coefficients and the
// highest index weight among them, given the chunk's base vector position.
module anf_lane_reduce
  import anf_pkg::*;
#(
  parameter int unsigned LOG2_N = 7,
  parameter int unsigned LANES = 8,
  localparam int unsigned DW = deg_width(LOG2_N),
  localparam int unsigned LW = $clog2(LANES) + 1
) (
  input  logic [LANES-1:0]  bits,
  input  logic [LOG2_N-1:0] base,
  output logic [LW-1:0]     lane_count,
  output logic [DW-1:0]     lane_degree
);

  logic [DW-1:0] weight [LANES];

  // base is LANES-aligned, so OR-ing the lane number yields the vector position.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      weight[j] = DW'(popcount(32'(base | LOG2_N'(j))));
    end
  end

  always_comb begin
    lane_count  = '0;
    lane_degree = '0;
    for (int j = 0; j < LANES; j++) begin
      if (bits[j]) begin
        lane_count = lane_count + LW'(1);
        if (weight[j] > lane_degree) begin
          lane_degree = weight[j];
        end
      end
    end
  end

endmodule

// File: rtl/anf_degree_scan.sv
// Captures one ANF coefficient vector per handshake, scans it LANES positions per
// cycle with fixed latency, and presents degree, monomial count and zero flag.
module anf_degree_scan
  import anf_pkg::*;
#(
  parameter int unsigned N = 128,
  parameter int unsigned LOG2_N = 7,
  parameter int unsigned LANES = 8,
  localparam int unsigned DW = deg_width(LOG2_N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:N-1]    in_anf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_degree,
  output logic [LOG2_N:0] out_count,
  output logic            out_zero
);

  localparam int unsigned CHUNKS = N / LANES;
  localparam int unsigned PW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned LW = $clog2(LANES) + 1;
  localparam int unsigned CW = cnt_width(LOG2_N);
  localparam logic [PW-1:0] LastPtr = PW'(CHUNKS - 1);

  anf_state_e state_q, state_d;
  logic [0:N-1]  anf_q, anf_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] deg_q, deg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;

  logic [LANES-1:0]  chunk;
  logic [LOG2_N-1:0] base;
  logic [LW-1:0]     lane_count;
  logic [DW-1:0]     lane_degree;
  logic [CW-1:0]     cnt_sum;

  // The shadow register shifts toward position 0, so the current chunk is always
  // at the front; ptr only supplies the index weights.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      chunk[j] = anf_q[j];
    end
  end

  assign base = LOG2_N'(ptr_q) << $clog2(LANES);

  anf_lane_reduce #(
    .LOG2_N(LOG2_N),
    .LANES (LANES)
  ) u_lane_reduce (
    .bits       (chunk),
    .base       (base),
    .lane_count (lane_count),
    .lane_degree(lane_degree)
  );

  assign cnt_sum = cnt_q + CW'(lane_count);

  always_comb begin
    state_d = state_q;
    anf_d   = anf_q;
    ptr_d   = ptr_q;
    deg_d   = deg_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          anf_d   = in_anf;
          ptr_d   = '0;
          deg_d   = '0;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        anf_d = anf_q << LANES;
        ptr_d = ptr_q + PW'(1);
        cnt_d = cnt_sum;
        if (lane_degree > deg_q) begin
          deg_d = lane_degree;
        end
        if (ptr_q == LastPtr) begin
          zero_d  = (cnt_sum == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      deg_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      deg_q   <= deg_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // Pure data; its contents only matter once a capture has occurred.
  always_ff @(posedge clk) begin
    anf_q <= anf_d;
  end

  assign in_ready   = (state_q == StIdle) && !rst;
  assign out_valid  = (state_q == StDone);
  assign out_degree = deg_q;
  assign out_count  = cnt_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_anf_degree_scan.sv
// Bench for anf_degree_scan: three instances (LANES 1/8/128) checked every cycle
// against a set-based reference model, plus directed literal scenarios.
module tb_anf_degree_scan;

  localparam int N = 128;
  localparam int LOG2_N = 7;

  logic clk = 1'b0;
  logic rst;

  logic         in_valid   [3];
  logic         in_ready   [3];
  logic [0:N-1] in_anf     [3];
  logic         out_valid  [3];
  logic         out_ready  [3];
  logic [2:0]   out_degree [3];
  logic [7:0]   out_count  [3];
  logic         out_zero   [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  anf_degree_scan #(.N(N), .LOG2_N(LOG2_N), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_anf(in_anf[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_degree(out_degree[0]), .out_count(out_count[0]), .out_zero(out_zero[0])
  );
  anf_degree_scan #(.N(N), .LOG2_N(LOG2_N), .LANES(8)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_anf(in_anf[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_degree(out_degree[1]), .out_count(out_count[1]), .out_zero(out_zero[1])
  );
  anf_degree_scan #(.N(N), .LOG2_N(LOG2_N), .LANES(128)) u_l128 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_anf(in_anf[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_degree(out_degree[2]), .out_count(out_count[2]), .out_zero(out_zero[2])
  );

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 128;
  endfunction

  function automatic int chunks_of(input int k);
    return N / lanes_of(k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: degree is the largest number of variables in any present monomial.
  function automatic void ref_model(input logic [0:N-1] v, output int deg, output int cnt);
    deg = 0;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        cnt++;
        if ($countones(i) > deg) deg = $countones(i);
      end
    end
  endfunction

  // Model state per instance.
  bit busy    [3];
  bit pending [3];
  int acc_cyc [3];
  int exp_deg [3];
  int exp_cnt [3];

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 3; k++) begin
        bit exp_valid;
        string tag;
        tag = $sformatf("L%0d", lanes_of(k));
        exp_valid = pending[k] && ((cyc - acc_cyc[k]) >= chunks_of(k));
        check({tag, "_in_ready"}, {31'd0, in_ready[k]}, {31'd0, !busy[k] && !rst});
        check({tag, "_out_valid"}, {31'd0, out_valid[k]}, {31'd0, exp_valid});
        if (exp_valid) begin
          check({tag, "_degree"}, {29'd0, out_degree[k]}, exp_deg[k]);
          check({tag, "_count"}, {24'd0, out_count[k]}, exp_cnt[k]);
          check({tag, "_zero"}, {31'd0, out_zero[k]}, {31'd0, exp_cnt[k] == 0});
        end
        if (rst) begin
          busy[k] = 1'b0;
          pending[k] = 1'b0;
        end else if (out_valid[k] && out_ready[k]) begin
          busy[k] = 1'b0;
          pending[k] = 1'b0;
        end else if (in_valid[k] && in_ready[k]) begin
          busy[k] = 1'b1;
          pending[k] = 1'b1;
          acc_cyc[k] = cyc + 1;
          ref_model(in_anf[k], exp_deg[k], exp_cnt[k]);
        end
      end
    end
  end

  // Entered and left at #1 after a rising edge; returns just after the accept edge.
  task automatic send(input int k, input logic [0:N-1] v, input string name);
    int t;
    t = 0;
    in_valid[k] = 1'b1;
    in_anf[k] = v;
    @(negedge clk);
    while (!in_ready[k] && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready[k]) begin
      errors++;
      $display("FAIL %s accept timeout: in_ready=0, expected 1", name);
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  // Returns at a falling edge with out_valid high (or after the bound expires).
  task automatic wait_valid(input int k, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid[k] && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!out_valid[k]) begin
      errors++;
      $display("FAIL %s result timeout: out_valid=0, expected 1", name);
    end
  endtask

  task automatic run_lit(input int k, input logic [0:N-1] v, input int d, input int c,
                         input int z, input int lat, input string name);
    int t0;
    out_ready[k] = 1'b1;
    send(k, v, name);
    t0 = cyc;
    wait_valid(k, name);
    check({name, "_deg"}, {29'd0, out_degree[k]}, d);
    check({name, "_cnt"}, {24'd0, out_count[k]}, c);
    check({name, "_zero"}, {31'd0, out_zero[k]}, z);
    if (lat > 0) check({name, "_latency"}, cyc - t0, lat);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:N-1] rand_vec();
    logic [0:N-1] v;
    int mode;
    v = '0;
    mode = $urandom_range(0, 4);
    case (mode)
      0, 1: for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
      2: repeat ($urandom_range(1, 6)) v[$urandom_range(0, N - 1)] = 1'b1;
      3: v = '0;
      default: begin
        v = '1;
        repeat ($urandom_range(0, 4)) v[$urandom_range(0, N - 1)] = 1'b0;
      end
    endcase
    return v;
  endfunction

  task automatic rand_run(input int k, input int n);
    int stall;
    string name;
    name = $sformatf("rand_L%0d", lanes_of(k));
    for (int i = 0; i < n; i++) begin
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      out_ready[k] = (stall == 0);
      send(k, rand_vec(), name);
      wait_valid(k, name);
      if (stall > 0) begin
        repeat (stall) @(posedge clk);
        #1;
        out_ready[k] = 1'b1;
      end
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [0:N-1] v;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      in_anf[k] = '0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_out_valid", {31'd0, out_valid[k]}, 0);
      check("reset_degree", {29'd0, out_degree[k]}, 0);
      check("reset_count", {24'd0, out_count[k]}, 0);
      check("reset_zero", {31'd0, out_zero[k]}, 0);
      check("reset_in_ready", {31'd0, in_ready[k]}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", {31'd0, in_ready[1]}, 1);
    @(posedge clk);
    #1;

    // Directed patterns on the LANES=8 instance.
    run_lit(1, '0, 0, 0, 1, 16, "all_zero");
    v = '0; v[0] = 1'b1;
    run_lit(1, v, 0, 1, 0, 0, "bit0");
    v = '0; v[127] = 1'b1;
    run_lit(1, v, 7, 1, 0, 0, "bit127");
    v = '0; v[3] = 1'b1; v[5] = 1'b1; v[6] = 1'b1;
    run_lit(1, v, 2, 3, 0, 0, "bits356");
    v[7] = 1'b1;
    run_lit(1, v, 3, 4, 0, 0, "bits3567");
    run_lit(1, '1, 7, 128, 0, 0, "all_ones");

    // Hold results in DONE while in_valid pulses with a different vector.
    out_ready[1] = 1'b0;
    v = '0; v[127] = 1'b1;
    send(1, v, "stall");
    wait_valid(1, "stall");
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid[1] = ~in_valid[1];
      in_anf[1] = '1;
    end
    @(negedge clk);
    check("stall_hold_deg", {29'd0, out_degree[1]}, 7);
    check("stall_hold_cnt", {24'd0, out_count[1]}, 1);
    check("stall_hold_ready", {31'd0, in_ready[1]}, 0);
    @(posedge clk);
    #1;
    v = '0; v[3] = 1'b1;
    in_valid[1] = 1'b1;
    in_anf[1] = v;
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("release_ready_before", {31'd0, in_ready[1]}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_ready_after", {31'd0, in_ready[1]}, 1);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    wait_valid(1, "after_stall");
    check("after_stall_deg", {29'd0, out_degree[1]}, 2);
    check("after_stall_cnt", {24'd0, out_count[1]}, 1);
    @(posedge clk);
    #1;

    // Reset during the 8th scan cycle aborts the vector.
    send(1, '1, "abort");
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready[1]}, 1);
    repeat (20) begin
      @(negedge clk);
      check("abort_no_valid", {31'd0, out_valid[1]}, 0);
    end
    @(posedge clk);
    #1;
    v = '0; v[63] = 1'b1;
    run_lit(1, v, 6, 1, 0, 16, "bit63");

    // Latency per lane width.
    v = '0; v[127] = 1'b1;
    run_lit(0, v, 7, 1, 0, 128, "lat_L1");
    run_lit(2, v, 7, 1, 0, 1, "lat_L128");

    fork
      rand_run(0, 250);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
